// File: rtl/bitserial_pkg.sv
// Shared types and helpers for the bitserial_nn weight path: FSM states,
// row-length rule and the default address widths of the weight memory.
package bitserial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int unsigned addr_w(input int unsigned n);
        return (n > 32'd1) ? $clog2(n) : 32'd1;
    endfunction

    // Layer 0 always sees the full input fan-in; packed hidden layers only N_HIDDEN.
    function automatic int unsigned row_len(input int unsigned layer, input bit pack_hidden,
                                            input int unsigned n_in, input int unsigned n_hidden);
        if (!pack_hidden || layer == 32'd0) begin
            return n_in;
        end else begin
            return n_hidden;
        end
    endfunction

    localparam int unsigned BN_N_IN     = 32'd512;
    localparam int unsigned BN_N_HIDDEN = 32'd256;
    localparam int unsigned BN_N_LAYERS = 32'd7;
    localparam int unsigned BN_L_W      = addr_w(BN_N_LAYERS);
    localparam int unsigned BN_H_W      = addr_w(BN_N_HIDDEN);
    localparam int unsigned BN_I_W      = addr_w(BN_N_IN);

endpackage

// File: rtl/bitserial_addr_gen.sv
// Nested layer/neuron/column counter for the weight loader, with clamped
// layer budget and end-of-row / end-of-layer / final-word flags.
module bitserial_addr_gen
    import bitserial_pkg::*;
#(
    parameter int unsigned N_IN        = 32'd512,
    parameter int unsigned N_HIDDEN    = 32'd256,
    parameter int unsigned N_LAYERS    = 32'd7,
    parameter int unsigned PACK_HIDDEN = 32'd1,
    localparam int unsigned LW = addr_w(N_LAYERS),
    localparam int unsigned HW = addr_w(N_HIDDEN),
    localparam int unsigned IW = addr_w(N_IN),
    localparam int unsigned NW = LW + 32'd1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          init_i,
    input  logic [LW-1:0] start_layer_i,
    input  logic [NW-1:0] num_layers_i,
    input  logic          advance_i,
    output logic [LW-1:0] l_o,
    output logic [HW-1:0] h_o,
    output logic [IW-1:0] i_o,
    output logic          layer_end_o,
    output logic          final_o
);

    logic [LW-1:0] l_q, l_d, sl_s;
    logic [HW-1:0] h_q, h_d;
    logic [IW-1:0] i_q, i_d, i_max_s;
    logic [NW-1:0] left_q, left_d, max_nl_s, nl_s;
    logic          row_end_s;

    // Clamp the requested window so the layer counter can never pass N_LAYERS-1.
    always_comb begin
        if (32'(start_layer_i) > N_LAYERS - 32'd1) begin
            sl_s = LW'(N_LAYERS - 32'd1);
        end else begin
            sl_s = start_layer_i;
        end
        max_nl_s = NW'(N_LAYERS) - {1'b0, sl_s};
        if (num_layers_i == {NW{1'b0}}) begin
            nl_s = NW'(32'd1);
        end else if (num_layers_i > max_nl_s) begin
            nl_s = max_nl_s;
        end else begin
            nl_s = num_layers_i;
        end
    end

    assign i_max_s     = IW'(row_len(32'(l_q), PACK_HIDDEN != 32'd0, N_IN, N_HIDDEN) - 32'd1);
    assign row_end_s   = (i_q == i_max_s);
    assign layer_end_o = row_end_s && (h_q == HW'(N_HIDDEN - 32'd1));
    assign final_o     = layer_end_o && (left_q == NW'(32'd1));

    // Counter next state: column, then neuron, then layer.
    always_comb begin
        l_d    = l_q;
        h_d    = h_q;
        i_d    = i_q;
        left_d = left_q;
        if (init_i) begin
            l_d    = sl_s;
            h_d    = {HW{1'b0}};
            i_d    = {IW{1'b0}};
            left_d = nl_s;
        end else if (advance_i) begin
            if (row_end_s) begin
                i_d = {IW{1'b0}};
                if (h_q == HW'(N_HIDDEN - 32'd1)) begin
                    h_d    = {HW{1'b0}};
                    left_d = left_q - NW'(32'd1);
                    if (left_q > NW'(32'd1)) begin
                        l_d = l_q + LW'(32'd1);
                    end else begin
                        l_d = l_q;
                    end
                end else begin
                    h_d = h_q + HW'(32'd1);
                end
            end else begin
                i_d = i_q + IW'(32'd1);
            end
        end else begin
            left_d = left_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            l_q    <= {LW{1'b0}};
            h_q    <= {HW{1'b0}};
            i_q    <= {IW{1'b0}};
            left_q <= {NW{1'b0}};
        end else begin
            l_q    <= l_d;
            h_q    <= h_d;
            i_q    <= i_d;
            left_q <= left_d;
        end
    end

    assign l_o = l_q;
    assign h_o = h_q;
    assign i_o = i_q;

endmodule

// File: rtl/bitserial_weight_loader.sv
// AXI-Stream front-end that writes bitserial_nn weight memory one layer per
// packet, checking tlast framing and signalling completion.
module bitserial_weight_loader
    import bitserial_pkg::*;
#(
    parameter int unsigned DATA_W      = 32'd16,
    parameter int unsigned N_IN        = 32'd512,
    parameter int unsigned N_HIDDEN    = 32'd256,
    parameter int unsigned N_LAYERS    = 32'd7,
    parameter int unsigned PACK_HIDDEN = 32'd1,
    localparam int unsigned LW = addr_w(N_LAYERS),
    localparam int unsigned HW = addr_w(N_HIDDEN),
    localparam int unsigned IW = addr_w(N_IN),
    localparam int unsigned NW = LW + 32'd1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic [LW-1:0]            start_layer_i,
    input  logic [NW-1:0]            num_layers_i,
    input  logic                     abort_i,
    input  logic [DATA_W-1:0]        s_axis_tdata_i,
    input  logic                     s_axis_tvalid_i,
    output logic                     s_axis_tready_o,
    input  logic                     s_axis_tlast_i,
    output logic                     w_wr_en_o,
    output logic [LW-1:0]            w_addr_l_o,
    output logic [HW-1:0]            w_addr_h_o,
    output logic [IW-1:0]            w_addr_i_o,
    output logic signed [DATA_W-1:0] w_data_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     err_framing_o
);

    state_e state_q, state_d;
    logic   hs_s, init_s, layer_end_s, final_s;
    logic   err_q, err_d, done_q, done_d, busy_q, busy_d, tready_q, tready_d;
    logic   wr_q;
    logic [LW-1:0] l_s, wl_q;
    logic [HW-1:0] h_s, wh_q;
    logic [IW-1:0] i_s, wi_q;
    logic signed [DATA_W-1:0] wd_q;

    // A word in the abort cycle is dropped even though tready is still high.
    assign hs_s   = s_axis_tvalid_i && (state_q == LOAD) && !abort_i;
    assign init_s = start_i && (state_q == IDLE) && !abort_i;

    bitserial_addr_gen #(
        .N_IN(N_IN), .N_HIDDEN(N_HIDDEN), .N_LAYERS(N_LAYERS), .PACK_HIDDEN(PACK_HIDDEN)
    ) u_addr_gen (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .init_i        (init_s),
        .start_layer_i (start_layer_i),
        .num_layers_i  (num_layers_i),
        .advance_i     (hs_s),
        .l_o           (l_s),
        .h_o           (h_s),
        .i_o           (i_s),
        .layer_end_o   (layer_end_s),
        .final_o       (final_s)
    );

    // FSM next state, framing check and registered status outputs.
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        done_d  = 1'b0;
        if (abort_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_d = LOAD;
                        err_d   = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
                LOAD: begin
                    if (hs_s) begin
                        if (s_axis_tlast_i && !layer_end_s) begin
                            err_d   = 1'b1;
                            state_d = DONE;
                        end else begin
                            if (!s_axis_tlast_i && layer_end_s) begin
                                err_d = 1'b1;
                            end else begin
                                err_d = err_q;
                            end
                            state_d = final_s ? DONE : LOAD;
                        end
                    end else begin
                        state_d = LOAD;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        tready_d = (state_d == LOAD);
        busy_d   = (state_d != IDLE) || hs_s;
    end

    // State and status registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            tready_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            err_q    <= err_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            tready_q <= tready_d;
        end
    end

    // Write-port register: one strobe per accepted word, one cycle later.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q <= 1'b0;
            wl_q <= {LW{1'b0}};
            wh_q <= {HW{1'b0}};
            wi_q <= {IW{1'b0}};
            wd_q <= {DATA_W{1'b0}};
        end else begin
            wr_q <= hs_s;
            if (hs_s) begin
                wl_q <= l_s;
                wh_q <= h_s;
                wi_q <= i_s;
                wd_q <= $signed(s_axis_tdata_i);
            end else begin
                wl_q <= wl_q;
                wh_q <= wh_q;
                wi_q <= wi_q;
                wd_q <= wd_q;
            end
        end
    end

    assign s_axis_tready_o = tready_q;
    assign w_wr_en_o       = wr_q;
    assign w_addr_l_o      = wl_q;
    assign w_addr_h_o      = wh_q;
    assign w_addr_i_o      = wi_q;
    assign w_data_o        = wd_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign err_framing_o   = err_q;

endmodule

// File: tb/tb_bitserial_weight_loader.sv
// Directed bench: instance a uses PACK_HIDDEN=1, instance b uses PACK_HIDDEN=0.
module tb_bitserial_weight_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  start_layer = 2'd0;
    logic [2:0]  num_layers = 3'd0;
    logic        abort = 1'b0;
    logic [15:0] tdata = 16'd0;
    logic        tvalid = 1'b0;
    logic        tlast = 1'b0;

    logic a_tready, a_wr, a_busy, a_done, a_err;
    logic [1:0] a_l, a_h;
    logic [2:0] a_i;
    logic signed [15:0] a_d;
    logic b_tready, b_wr, b_busy, b_done, b_err;
    logic [1:0] b_l, b_h;
    logic [2:0] b_i;
    logic signed [15:0] b_d;

    int n_assert = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    bitserial_weight_loader #(.DATA_W(16), .N_IN(8), .N_HIDDEN(4), .N_LAYERS(3), .PACK_HIDDEN(1)) dut_a (
        .clk_i(clk), .rst_i(rst), .start_i(start), .start_layer_i(start_layer),
        .num_layers_i(num_layers), .abort_i(abort), .s_axis_tdata_i(tdata),
        .s_axis_tvalid_i(tvalid), .s_axis_tready_o(a_tready), .s_axis_tlast_i(tlast),
        .w_wr_en_o(a_wr), .w_addr_l_o(a_l), .w_addr_h_o(a_h), .w_addr_i_o(a_i),
        .w_data_o(a_d), .busy_o(a_busy), .done_o(a_done), .err_framing_o(a_err));

    bitserial_weight_loader #(.DATA_W(16), .N_IN(8), .N_HIDDEN(4), .N_LAYERS(3), .PACK_HIDDEN(0)) dut_b (
        .clk_i(clk), .rst_i(rst), .start_i(start), .start_layer_i(start_layer),
        .num_layers_i(num_layers), .abort_i(abort), .s_axis_tdata_i(tdata),
        .s_axis_tvalid_i(tvalid), .s_axis_tready_o(b_tready), .s_axis_tlast_i(tlast),
        .w_wr_en_o(b_wr), .w_addr_l_o(b_l), .w_addr_h_o(b_h), .w_addr_i_o(b_i),
        .w_data_o(b_d), .busy_o(b_busy), .done_o(b_done), .err_framing_o(b_err));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {l,h,i} of word k of a load starting at layer sl, by walking layer sizes.
    function automatic logic [6:0] exp_addr(input int k, input int sl, input bit pack);
        int l, rem, len;
        l = sl;
        rem = k;
        len = (pack && l != 0) ? 16 : 32;
        while (rem >= len) begin
            rem -= len;
            l++;
            len = (pack && l != 0) ? 16 : 32;
        end
        return {2'(l), 2'(rem / (len / 4)), 3'(rem % (len / 4))};
    endfunction

    function automatic logic [23:0] obs_wr(input bit sel_b);
        return sel_b ? {b_wr, b_l, b_h, b_i, b_d} : {a_wr, a_l, a_h, a_i, a_d};
    endfunction

    // {wr, busy, done, err, tready}
    function automatic logic [4:0] obs_st(input bit sel_b);
        return sel_b ? {b_wr, b_busy, b_done, b_err, b_tready} : {a_wr, a_busy, a_done, a_err, a_tready};
    endfunction

    task automatic do_start(input logic [1:0] sl, input logic [2:0] nl);
        start = 1'b1; start_layer = sl; num_layers = nl; tvalid = 1'b0; tlast = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk("start_status", 32'(obs_st(1'b0)), 32'b01001);
    endtask

    task automatic xfer(input int k, input logic [15:0] d, input logic last, input int sl, input bit sel_b);
        tvalid = 1'b1; tdata = d; tlast = last;
        @(negedge clk);
        chk($sformatf("write_k%0d", k), 32'(obs_wr(sel_b)), 32'({1'b1, exp_addr(k, sl, !sel_b), d}));
    endtask

    task automatic gap(input bit sel_b);
        tvalid = 1'b0; tlast = 1'b0;
        @(negedge clk);
        chk("gap_no_write", 32'(obs_st(sel_b) >> 4), 32'd0);
    endtask

    task automatic finish_load(input bit sel_b, input logic exp_err);
        tvalid = 1'b0; tlast = 1'b0;
        @(negedge clk);
        chk("done_pulse", 32'(obs_st(sel_b)), 32'({4'b0010, 1'b0} | {3'b000, exp_err, 1'b0}));
        @(negedge clk);
        chk("done_once", 32'(obs_st(sel_b)), 32'({3'b000, exp_err, 1'b0}));
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_wr", 32'(obs_wr(1'b0)), 32'd0);
        chk("reset_st", 32'(obs_st(1'b0)), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1: full packed load, data=k
        do_start(2'd0, 3'd3);
        for (int k = 0; k < 64; k++) xfer(k, 16'(k), (k == 31 || k == 47 || k == 63), 0, 1'b0);
        chk("w32_addr", 32'(exp_addr(32, 0, 1'b1)), 32'({2'd1, 2'd0, 3'd0}));
        finish_load(1'b0, 1'b0);

        // 2: unpacked instance needs 96 words
        do_start(2'd0, 3'd3);
        for (int k = 0; k < 96; k++) xfer(k, 16'h4000 + 16'(k), (k == 31 || k == 63 || k == 95), 0, 1'b1);
        finish_load(1'b1, 1'b0);

        // 3: random valid gaps
        do_start(2'd0, 3'd3);
        for (int k = 0; k < 64; k++) begin
            if ($urandom_range(0, 1) == 1) gap(1'b0);
            xfer(k, 16'h8000 ^ 16'(k * 7), (k == 31 || k == 47 || k == 63), 0, 1'b0);
        end
        finish_load(1'b0, 1'b0);

        // 4a: early tlast on word 10, later words refused
        do_start(2'd0, 3'd3);
        for (int k = 0; k < 11; k++) xfer(k, 16'h0100 + 16'(k), (k == 10), 0, 1'b0);
        tvalid = 1'b1; tdata = 16'h0111; tlast = 1'b0;
        chk("early_tready", 32'(a_tready), 32'd0);
        @(negedge clk);
        chk("early_done", 32'(obs_st(1'b0)), 32'b00110);
        @(negedge clk);
        chk("early_after", 32'(obs_st(1'b0)), 32'b00010);
        tvalid = 1'b0;

        // 4b: missing tlast on word 31
        do_start(2'd0, 3'd3);
        for (int k = 0; k < 64; k++) xfer(k, 16'h0200 + 16'(k), (k == 47 || k == 63), 0, 1'b0);
        finish_load(1'b0, 1'b1);

        // 5a: partial load of layer 2 only
        do_start(2'd2, 3'd1);
        for (int k = 0; k < 16; k++) xfer(k, 16'hF000 + 16'(k), (k == 15), 2, 1'b0);
        finish_load(1'b0, 1'b0);

        // 5b: abort after word 5 (num_layers clamped)
        do_start(2'd2, 3'd6);
        for (int k = 0; k < 6; k++) xfer(k, 16'h0300 + 16'(k), 1'b0, 2, 1'b0);
        abort = 1'b1; tvalid = 1'b1; tdata = 16'h0306;
        @(negedge clk);
        abort = 1'b0; tvalid = 1'b0;
        chk("abort_st", 32'(obs_st(1'b0)), 32'd0);
        @(negedge clk);
        chk("abort_after", 32'(obs_st(1'b0)), 32'd0);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("start_abort", 32'(obs_st(1'b0)), 32'd0);

        // 6: asynchronous reset mid-load, then restart at layer 1 (num_layers 0 -> 1)
        do_start(2'd0, 3'd3);
        for (int k = 0; k < 21; k++) xfer(k, 16'h0400 + 16'(k), 1'b0, 0, 1'b0);
        tvalid = 1'b1; tdata = 16'h0415;
        #2 rst = 1'b1;
        #1;
        chk("async_rst_wr", 32'(obs_wr(1'b0)), 32'd0);
        chk("async_rst_st", 32'(obs_st(1'b0)), 32'd0);
        @(negedge clk);
        rst = 1'b0; tvalid = 1'b0;
        @(negedge clk);
        do_start(2'd1, 3'd0);
        for (int k = 0; k < 16; k++) xfer(k, 16'h0500 + 16'(k), (k == 15), 1, 1'b0);
        finish_load(1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
